pll_lock_supervisor: RTL and testbench

PLL_LOCK_SUPERVISOR -- requirements
Module: pll_lock_supervisor

---
 rtl/pll_lock_supervisor.sv | 172 +++++++++++++++++
 tb/tb_pll_lock_supervisor.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/pll_lock_supervisor.sv
// PLL reset sequencer: pulses pll_rst, waits for a stable lock, then releases sys_rst.
// Define PLL_SUP_LOCK_FILTER_EN to debounce lock loss in RUN over FILTER_CYCLES cycles.
module pll_lock_supervisor #(
   parameter int RST_CYCLES    = 16,
   parameter int LOCK_TIMEOUT  = 50000,
   parameter int STABLE_CYCLES = 1024,
   parameter int MAX_RETRY     = 3,
   parameter int FILTER_CYCLES = 4
) (
   input  logic       refclk,
   input  logic       rst,
   input  logic       locked,
   output logic       pll_rst,
   output logic       sys_rst,
   output logic       ready,
   output logic       fail,
   output logic [7:0] relock_count
);

   typedef enum logic [2:0] {
      PRST,
      WAIT_LOCK,
      STABLE,
      RUN,
      FAIL
   } state_t;

   localparam logic [7:0]  RST_LAST  = 8'(RST_CYCLES - 1);
   localparam logic [19:0] TMO_LAST  = 20'(LOCK_TIMEOUT - 1);
   localparam logic [15:0] STB_LAST  = 16'(STABLE_CYCLES - 1);
   localparam logic [3:0]  RETRY_MAX = 4'(MAX_RETRY);

   state_t      state_reg;
   logic [1:0]  sync_reg;
   logic [7:0]  rst_cnt_reg;
   logic [19:0] tmo_cnt_reg;
   logic [15:0] stb_cnt_reg;
   logic [3:0]  attempt_reg;
   logic [7:0]  relock_reg;
   logic        pll_rst_reg;
   logic        sys_rst_reg;
   logic        ready_reg;
   logic        fail_reg;
   logic        lock_s;
   logic        loss_q;

   // locked comes from the PLL's own lock detector and is asynchronous to refclk
   always_ff @(posedge refclk or posedge rst) begin
      if (rst) begin
         sync_reg <= 2'b00;
      end else begin
         sync_reg <= {sync_reg[0], locked};
      end
   end

   assign lock_s = sync_reg[1];

`ifdef PLL_SUP_LOCK_FILTER_EN
   localparam logic [7:0] FLT_LAST = 8'(FILTER_CYCLES - 1);

   logic [7:0] flt_cnt_reg;

   // Counts consecutive low lock_s cycles in RUN; cleared outside RUN so every entry starts fresh
   always_ff @(posedge refclk or posedge rst) begin
      if (rst) begin
         flt_cnt_reg <= 8'd0;
      end else if (state_reg != RUN || lock_s) begin
         flt_cnt_reg <= 8'd0;
      end else if (flt_cnt_reg != FLT_LAST) begin
         flt_cnt_reg <= flt_cnt_reg + 8'd1;
      end
   end

   assign loss_q = (state_reg == RUN) && !lock_s && (flt_cnt_reg == FLT_LAST);
`else
   assign loss_q = (state_reg == RUN) && !lock_s;
`endif

   always_ff @(posedge refclk or posedge rst) begin
      if (rst) begin
         state_reg   <= PRST;
         rst_cnt_reg <= 8'd0;
         tmo_cnt_reg <= 20'd0;
         stb_cnt_reg <= 16'd0;
         attempt_reg <= 4'd0;
         relock_reg  <= 8'd0;
         pll_rst_reg <= 1'b1;
         sys_rst_reg <= 1'b1;
         ready_reg   <= 1'b0;
         fail_reg    <= 1'b0;
      end else begin
         case (state_reg)
            PRST: begin
               if (rst_cnt_reg == RST_LAST) begin
                  state_reg   <= WAIT_LOCK;
                  pll_rst_reg <= 1'b0;
                  tmo_cnt_reg <= 20'd0;
                  if (attempt_reg != 4'hF) begin
                     attempt_reg <= attempt_reg + 4'd1;
                  end
               end else begin
                  rst_cnt_reg <= rst_cnt_reg + 8'd1;
               end
            end
            WAIT_LOCK: begin
               // Lock is tested first so it wins over a simultaneous timeout
               if (lock_s) begin
                  state_reg   <= STABLE;
                  stb_cnt_reg <= 16'd0;
               end else if (tmo_cnt_reg == TMO_LAST) begin
                  pll_rst_reg <= 1'b1;
                  if (attempt_reg < RETRY_MAX) begin
                     state_reg   <= PRST;
                     rst_cnt_reg <= 8'd0;
                  end else begin
                     state_reg <= FAIL;
                     fail_reg  <= 1'b1;
                  end
               end else begin
                  tmo_cnt_reg <= tmo_cnt_reg + 20'd1;
               end
            end
            STABLE: begin
               if (!lock_s) begin
                  state_reg   <= WAIT_LOCK;
                  tmo_cnt_reg <= 20'd0;
               end else if (stb_cnt_reg == STB_LAST) begin
                  state_reg   <= RUN;
                  sys_rst_reg <= 1'b0;
                  ready_reg   <= 1'b1;
               end else begin
                  stb_cnt_reg <= stb_cnt_reg + 16'd1;
               end
            end
            RUN: begin
               if (loss_q) begin
                  state_reg   <= PRST;
                  rst_cnt_reg <= 8'd0;
                  attempt_reg <= 4'd0;
                  pll_rst_reg <= 1'b1;
                  sys_rst_reg <= 1'b1;
                  ready_reg   <= 1'b0;
                  if (relock_reg != 8'hFF) begin
                     relock_reg <= relock_reg + 8'd1;
                  end
               end
            end
            FAIL: begin
               pll_rst_reg <= 1'b1;
               sys_rst_reg <= 1'b1;
               ready_reg   <= 1'b0;
               fail_reg    <= 1'b1;
            end
            default: begin
               state_reg   <= PRST;
               rst_cnt_reg <= 8'd0;
               pll_rst_reg <= 1'b1;
               sys_rst_reg <= 1'b1;
               ready_reg   <= 1'b0;
               fail_reg    <= 1'b0;
            end
         endcase
      end
   end

   assign pll_rst      = pll_rst_reg;
   assign sys_rst      = sys_rst_reg;
   assign ready        = ready_reg;
   assign fail         = fail_reg;
   assign relock_count = relock_reg;

endmodule

// File: tb/tb_pll_lock_supervisor.sv
// Directed bench for pll_lock_supervisor: boot table plus hand-timed retry, dropout and reset sequences.
module tb_pll_lock_supervisor;

   logic       refclk = 1'b0;
   logic       rst    = 1'b1;
   logic       locked = 1'b1;
   logic       pll_rst;
   logic       sys_rst;
   logic       ready;
   logic       fail;
   logic [7:0] relock_count;

   int checks   = 0;
   int failures = 0;

   typedef struct packed {
      logic       lck;
      logic       pll;
      logic       sys;
      logic       rdy;
      logic       fl;
      logic [7:0] rel;
   } vec_t;

   vec_t tv [14];

   pll_lock_supervisor #(
      .RST_CYCLES   (4),
      .LOCK_TIMEOUT (20),
      .STABLE_CYCLES(8),
      .MAX_RETRY    (2),
      .FILTER_CYCLES(3)
   ) dut (
      .refclk      (refclk),
      .rst         (rst),
      .locked      (locked),
      .pll_rst     (pll_rst),
      .sys_rst     (sys_rst),
      .ready       (ready),
      .fail        (fail),
      .relock_count(relock_count)
   );

   always #5 refclk = ~refclk;

   task automatic step();
      @(posedge refclk);
      #1;
   endtask

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0d expected %0d at t=%0t", name, act, exp, $time);
      end
   endtask

   task automatic chk_out(input string tag, input logic p, input logic s, input logic r,
                          input logic f, input logic [7:0] rl);
      chk($sformatf("%s.pll_rst", tag), 32'(pll_rst), 32'(p));
      chk($sformatf("%s.sys_rst", tag), 32'(sys_rst), 32'(s));
      chk($sformatf("%s.ready", tag), 32'(ready), 32'(r));
      chk($sformatf("%s.fail", tag), 32'(fail), 32'(f));
      chk($sformatf("%s.relock", tag), 32'(relock_count), 32'(rl));
   endtask

   task automatic do_reset(input logic lk);
      rst    = 1'b1;
      locked = lk;
      step();
      step();
      rst = 1'b0;
   endtask

   task automatic wait_ready(input string tag);
      for (int n = 0; n < 60 && ready !== 1'b1; n++) begin
         step();
      end
      chk(tag, 32'(ready), 32'd1);
   endtask

   // Entry i holds the outputs expected just after edge i+1 following rst release
   task automatic apply_table(input string tag);
      for (int i = 0; i < 14; i++) begin
         locked = tv[i].lck;
         step();
         $display("%s k=%0d pll_rst=%0b sys_rst=%0b ready=%0b fail=%0b relock=%0d",
                  tag, i + 1, pll_rst, sys_rst, ready, fail, relock_count);
         chk_out($sformatf("%s k=%0d", tag, i + 1), tv[i].pll, tv[i].sys, tv[i].rdy,
                 tv[i].fl, tv[i].rel);
      end
   endtask

   initial begin
      // Edges 1-3: still in PRST. Edge 4 enters WAIT_LOCK with lock_s already high,
      // edge 5 enters STABLE, eight STABLE cycles later edge 13 enters RUN.
      tv[0]  = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 8'd0};
      tv[1]  = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 8'd0};
      tv[2]  = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 8'd0};
      tv[3]  = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 8'd0};
      tv[4]  = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 8'd0};
      tv[5]  = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 8'd0};
      tv[6]  = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 8'd0};
      tv[7]  = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 8'd0};
      tv[8]  = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 8'd0};
      tv[9]  = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 8'd0};
      tv[10] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 8'd0};
      tv[11] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 8'd0};
      tv[12] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 8'd0};
      tv[13] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 8'd0};

      rst    = 1'b1;
      locked = 1'b1;
      step();
      step();
      chk_out("reset", 1'b1, 1'b1, 1'b0, 1'b0, 8'd0);
      rst = 1'b0;
      apply_table("boot");

      // RUN dropout: locked low for one cycle after edge 14, lock_s low only after edge 16
      do_reset(1'b1);
      repeat (14) step();
      locked = 1'b0;
      step();
      locked = 1'b1;
      step();
      chk_out("drop1 k=16", 1'b0, 1'b0, 1'b1, 1'b0, 8'd0);
      step();
`ifdef PLL_SUP_LOCK_FILTER_EN
      chk_out("drop1 k=17", 1'b0, 1'b0, 1'b1, 1'b0, 8'd0);
      locked = 1'b0;
      step();
      step();
      locked = 1'b1;
      for (int k = 20; k <= 25; k++) begin
         step();
         chk_out($sformatf("drop2 k=%0d", k), 1'b0, 1'b0, 1'b1, 1'b0, 8'd0);
      end
      locked = 1'b0;
      repeat (3) step();
      locked = 1'b1;
      step();
      chk_out("drop3 k=29", 1'b0, 1'b0, 1'b1, 1'b0, 8'd0);
      step();
      chk_out("drop3 k=30", 1'b1, 1'b1, 1'b0, 1'b0, 8'd1);
`else
      chk_out("drop1 k=17", 1'b1, 1'b1, 1'b0, 1'b0, 8'd1);
      repeat (12) step();
      chk_out("relock k=29", 1'b0, 1'b1, 1'b0, 1'b0, 8'd1);
      step();
      chk_out("relock k=30", 1'b0, 1'b0, 1'b1, 1'b0, 8'd1);
`endif
      $display("run dropout sequence done relock=%0d", relock_count);

      // STABLE dropout seen at stable count 5: back to WAIT_LOCK, RUN slips from edge 13 to 20
      do_reset(1'b1);
      repeat (8) step();
      locked = 1'b0;
      step();
      locked = 1'b1;
      for (int k = 10; k <= 20; k++) begin
         step();
         chk_out($sformatf("stable_drop k=%0d", k), 1'b0, k < 20, k >= 20, 1'b0, 8'd0);
      end
      $display("stable dropout sequence done ready=%0b", ready);

      // Never locks: PRST 0-3, WAIT 4-23, PRST 24-27, WAIT 28-47, FAIL from edge 48
      do_reset(1'b0);
      for (int k = 1; k <= 60; k++) begin
         step();
         chk_out($sformatf("nolock k=%0d", k),
                 (k < 4) || (k >= 24 && k < 28) || (k >= 48), 1'b1, 1'b0, k >= 48, 8'd0);
      end
      repeat (40) step();
      chk_out("nolock hold", 1'b1, 1'b1, 1'b0, 1'b1, 8'd0);
      $display("no-lock sequence done fail=%0b", fail);

      // 300 forced lock losses; relock_count must stop at 255
      do_reset(1'b1);
      wait_ready("sat boot ready");
      for (int i = 1; i <= 300; i++) begin
         locked = 1'b0;
         repeat (6) step();
         locked = 1'b1;
         wait_ready($sformatf("sat ready i=%0d", i));
         chk($sformatf("sat relock i=%0d", i), 32'(relock_count), (i < 255) ? 32'(i) : 32'd255);
         $display("loss %0d relock=%0d", i, relock_count);
      end

      // Reset mid-RUN takes effect without a clock edge, then a full boot follows
      rst = 1'b1;
      #1;
      chk_out("rst_in_run", 1'b1, 1'b1, 1'b0, 1'b0, 8'd0);
      step();
      step();
      rst = 1'b0;
      apply_table("reboot");

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
